demux_1x16_tdm: RTL and testbench

Time-division demultiplexer: the receive-side counterpart of the 16:1 channel multiplexer in the multiplexers library. It accepts a serial bit stream in which each frame carries one bit per channel, slot 0 first, and the first bit of every frame is marked by a sync strobe. It assembles each frame into a 16-bit shadow register and publishes the completed frame to registered per-channel outputs with a one-cycle valid pulse. Frame-alignment errors are detected and trigger automatic resynchronisation.

---
 rtl/demux_1x16_tdm.sv | 95 +++++++++
 tb/tb_demux_1x16_tdm.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x16_tdm.sv
// demux_1x16_tdm: TDM receive demultiplexer.
// Rebuilds sync-framed serial slots into parallel channels.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   din          serial bit for the current slot
//   din_valid    din qualifier; slots advance only when high
//   frame_sync   marks din as slot 0 (qualified by din_valid)
//   ch_out       last completed frame, bit i = channel i
//   frame_valid  one-cycle pulse when ch_out updates
//   slot         slot index the next valid bit goes to
//   locked       high while aligned (RECV)
//   sync_err     one-cycle pulse on an alignment error
module demux_1x16_tdm #(
    parameter int NUM_CH = 16,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [NUM_CH-1:0] ch_out,
    output logic              frame_valid,
    output logic [SEL_W-1:0]  slot,
    output logic              locked,
    output logic              sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(NUM_CH - 1);

    state_t            state;
    logic [NUM_CH-1:0] shadow;

    logic short_frame;
    logic missing_sync;
    logic last_slot;

    assign short_frame  = frame_sync && (slot != '0);
    assign missing_sync = !frame_sync && (slot == '0);
    assign last_slot    = (slot == SLOT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= '0;
            shadow      <= '0;
            ch_out      <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                if (state == HUNT) begin
                    if (frame_sync) begin
                        shadow[0] <= din;
                        slot      <= SLOT_ONE;
                        state     <= RECV;
                        locked    <= 1'b1;
                    end
                end else begin
                    if (short_frame) begin
                        // Resync on the early strobe; partial frame dropped.
                        sync_err  <= 1'b1;
                        shadow[0] <= din;
                        slot      <= SLOT_ONE;
                    end else if (missing_sync) begin
                        sync_err <= 1'b1;
                        state    <= HUNT;
                        locked   <= 1'b0;
                    end else if (last_slot) begin
                        // Top bit comes straight from din so the frame
                        // publishes on the same edge it completes.
                        shadow[NUM_CH-1] <= din;
                        ch_out      <= {din, shadow[NUM_CH-2:0]};
                        frame_valid <= 1'b1;
                        slot        <= '0;
                    end else begin
                        shadow[slot] <= din;
                        slot         <= slot + SLOT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1x16_tdm.sv
// tb_demux_1x16_tdm: directed bench for demux_1x16_tdm.
// Hand-computed frames, one check task, one summary line.
module tb_demux_1x16_tdm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [15:0] ch_out;
    logic        frame_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        sync_err;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fv_cyc = 0;
    int          lat_a;
    int          lat_b;
    int          t_first;
    logic [15:0] exp_ch = 16'h0000;

    demux_1x16_tdm #(.NUM_CH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_out     (ch_out),
        .frame_valid(frame_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic d);
        din_valid  = v;
        frame_sync = s;
        din        = d;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        exp_ch = 16'h0000;
    endtask

    // Sends one frame, slot 0 first with sync. Optional 3-cycle gaps
    // after slots 4 and 11 (frame_sync held high there, must be ignored).
    task automatic send_frame(input logic [15:0] w, input bit gaps,
                              input logic err0, output int lat);
        int start;
        start = cyc;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i == 0, w[i]);
            chk("sync_err", {31'd0, sync_err}, (i == 0) ? {31'd0, err0} : 0);
            if (i < 15) begin
                chk("fv_early", {31'd0, frame_valid}, 0);
                chk("ch_hold", {16'd0, ch_out}, {16'd0, exp_ch});
                chk("slot", {28'd0, slot}, i + 1);
                chk("locked", {31'd0, locked}, 1);
            end
            if (gaps && (i == 4 || i == 11)) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b1, ~w[i]);
                    chk("gap_slot", {28'd0, slot}, i + 1);
                    chk("gap_fv", {31'd0, frame_valid}, 0);
                end
            end
        end
        lat = cyc - start;
        exp_ch = w;
        chk("fv", {31'd0, frame_valid}, 1);
        chk("ch_out", {16'd0, ch_out}, {16'd0, w});
        chk("slot_wrap", {28'd0, slot}, 0);
        fv_cyc = cyc;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ch", {16'd0, ch_out}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_slot", {28'd0, slot}, 0);
        chk("rst_fv", {31'd0, frame_valid}, 0);
        chk("rst_err", {31'd0, sync_err}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // HUNT discards unsynced bits.
        step(1'b1, 1'b0, 1'b1);
        chk("hunt_slot", {28'd0, slot}, 0);
        chk("hunt_lock", {31'd0, locked}, 0);

        // Lock and single frame.
        send_frame(16'h5555, 1'b0, 1'b0, lat_a);
        chk("lat_plain", lat_a, 16);
        chk("lock1", {31'd0, locked}, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("fv_one_cycle", {31'd0, frame_valid}, 0);
        chk("ch_keep", {16'd0, ch_out}, 16'h5555);

        // Gapped valid: 6 extra cycles.
        send_frame(16'h5555, 1'b1, 1'b0, lat_b);
        chk("lat_gap", lat_b - lat_a, 6);

        // Short frame.
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
        chk("short_slot", {28'd0, slot}, 7);
        send_frame(16'hA5C3, 1'b0, 1'b1, lat_a);
        step(1'b0, 1'b0, 1'b0);
        chk("short_err_off", {31'd0, sync_err}, 0);

        // Missing sync.
        send_frame(16'h1234, 1'b0, 1'b0, lat_a);
        step(1'b1, 1'b0, 1'b1);
        chk("miss_err", {31'd0, sync_err}, 1);
        chk("miss_fv", {31'd0, frame_valid}, 0);
        chk("miss_lock", {31'd0, locked}, 0);
        chk("miss_ch", {16'd0, ch_out}, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("miss_ign_slot", {28'd0, slot}, 0);
            chk("miss_ign_err", {31'd0, sync_err}, 0);
            chk("miss_ign_ch", {16'd0, ch_out}, 16'h1234);
        end

        // Back-to-back frames.
        send_frame(16'hFFFF, 1'b0, 1'b0, lat_a);
        t_first = fv_cyc;
        send_frame(16'h0001, 1'b0, 1'b0, lat_b);
        chk("b2b_gap", fv_cyc - t_first, 16);

        // Reset mid-frame at slot 9.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 9; i++) step(1'b1, 1'b0, 1'b1);
        chk("pre_rst_slot", {28'd0, slot}, 9);
        din_valid = 1'b1;
        frame_sync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ch", {16'd0, ch_out}, 0);
        chk("arst_lock", {31'd0, locked}, 0);
        chk("arst_slot", {28'd0, slot}, 0);
        #1 rst_n = 1'b1;
        exp_ch = 16'h0000;
        send_frame(16'h9C3E, 1'b0, 1'b0, lat_a);
        chk("post_rst_lat", lat_a, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
